uart_tx_fifo_param: RTL and testbench

//  Parametrised UART transmitter: configurable data width, parity and stop bits, with a

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo_param_fifo.sv | 49 ++++
 rtl/uart_tx_fifo_param.sv | 139 +++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmitter types and helpers.
// Parity modes, transmitter FSM encoding, baud divisor.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_t;

  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_param_fifo.sv
// Synchronous FIFO with occupancy count.
// Extra level bit separates full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       Clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter fed by a small FIFO.
// Frames are sent back-to-back, LSB first.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int ClkFreq    = 50000000,
  parameter int B_Rate     = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          Clk,
  input  logic                          reset_n,
  input  logic                          In_Valid,
  output logic                          In_Ready,
  input  logic [DATA_BITS-1:0]          In_Data,
  output logic                          Serial,
  output logic                          Busy,
  output logic                          Transmit_Done,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level
);

  localparam int CPB = clks_per_bit(ClkFreq, B_Rate);
  localparam int CW  = $clog2(CPB);

  tx_state_t            state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 rdy_q;

  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 bit_end;

  assign In_Ready = rdy_q & ~fifo_full;
  assign bit_end  = (baud_q == CW'(CPB-1));
  assign Busy     = (state_q != TX_IDLE) | (Fifo_Level != '0);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .reset_n (reset_n),
    .push    (In_Valid & In_Ready),
    .wdata   (In_Data),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (Fifo_Level)
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    baud_d        = bit_end ? '0 : baud_q + 1'b1;
    bit_d         = bit_q;
    shreg_d       = shreg_q;
    par_d         = par_q;
    fifo_pop      = 1'b0;
    Transmit_Done = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) fifo_pop = 1'b1;
      end
      TX_START: begin
        if (bit_end) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == 4'(DATA_BITS-1)) begin
            bit_d   = '0;
            state_d = (PARITY == PARITY_NONE) ? TX_STOP : TX_PAR;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      TX_PAR: begin
        if (bit_end) state_d = TX_STOP;
      end
      TX_STOP: begin
        if (bit_end) begin
          if (bit_q == 4'(STOP_BITS-1)) begin
            Transmit_Done = 1'b1;
            state_d       = TX_IDLE;
            if (!fifo_empty) fifo_pop = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
    // Frame start: load the head word and restart bit timing
    if (fifo_pop) begin
      shreg_d = fifo_rdata;
      par_d   = (PARITY == PARITY_ODD) ? ~^fifo_rdata : ^fifo_rdata;
      baud_d  = '0;
      bit_d   = '0;
      state_d = TX_START;
    end
  end

  always_comb begin
    unique case (state_q)
      TX_START: Serial = 1'b0;
      TX_DATA:  Serial = shreg_q[0];
      TX_PAR:   Serial = par_q;
      default:  Serial = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Scoreboard bench for uart_tx_fifo_param.
// Two instances: 8N1 and 7-bit odd parity, two stop bits.
module tb_uart_tx_fifo_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v0 = 1'b0;
  logic [7:0] d0 = '0;
  logic       r0, s0, b0, dn0;
  logic [2:0] l0;
  logic       v1 = 1'b0;
  logic [6:0] d1 = '0;
  logic       r1, s1, b1, dn1;
  logic [2:0] l1;

  uart_tx_fifo_param #(
    .ClkFreq(160), .B_Rate(10), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut0 (
    .Clk(clk), .reset_n(rst_n), .In_Valid(v0), .In_Ready(r0),
    .In_Data(d0), .Serial(s0), .Busy(b0), .Transmit_Done(dn0),
    .Fifo_Level(l0)
  );

  uart_tx_fifo_param #(
    .ClkFreq(160), .B_Rate(10), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_dut1 (
    .Clk(clk), .reset_n(rst_n), .In_Valid(v1), .In_Ready(r1),
    .In_Data(d1), .Serial(s1), .Busy(b1), .Transmit_Done(dn1),
    .Fifo_Level(l1)
  );

  int n_err = 0;
  int n_chk = 0;
  int dcnt[2] = '{0, 0};
  int nfr[2] = '{0, 0};
  int gap[2] = '{-1, -1};
  time end_t[2] = '{0, 0};
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] bw[5] = '{8'h01, 8'h80, 8'hFF, 8'h5A, 8'hC6};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic ser(input int id);
    return (id == 0) ? s0 : s1;
  endfunction
  function automatic logic done(input int id);
    return (id == 0) ? dn0 : dn1;
  endfunction
  function automatic logic busy(input int id);
    return (id == 0) ? b0 : b1;
  endfunction
  function automatic logic rdy(input int id);
    return (id == 0) ? r0 : r1;
  endfunction
  function automatic int qsz(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  // Line bits in time order, start bit at index 0
  function automatic logic [15:0] exp_frame(input int id, input logic [7:0] w);
    logic [6:0] w7;
    w7 = w[6:0];
    if (id == 0) return {6'b0, 1'b1, w, 1'b0};
    return {5'b0, 2'b11, ~^w7, w7, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (dn0 === 1'b1) dcnt[0]++;
    if (dn1 === 1'b1) dcnt[1]++;
  end

  task automatic watch(input int id);
    logic [15:0] ex, ob;
    logic [7:0]  w;
    logic        sv, bv, stab, dok, ab;
    int          nb;
    nb = (id == 0) ? 10 : 11;
    forever begin
      while (ser(id) !== 1'b0 || rst_n !== 1'b1) @(negedge clk);
      gap[id] = int'(($time - end_t[id]) / 10);
      check("q_nonempty", qsz(id) > 0, 1);
      w = '0;
      if (id == 0 && q0.size() > 0) w = q0.pop_front();
      else if (id == 1 && q1.size() > 0) w = q1.pop_front();
      ex = exp_frame(id, w);
      ob = '0; bv = 1'b0; stab = 1'b1; dok = 1'b1; ab = 1'b0;
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < 16; k++) begin
          if (rst_n !== 1'b1) begin ab = 1'b1; break; end
          sv = ser(id);
          if (k == 0) bv = sv;
          else if (sv !== bv) stab = 1'b0;
          if (done(id) !== ((b == nb-1) && (k == 15))) dok = 1'b0;
          @(negedge clk);
        end
        if (ab) break;
        ob[b] = bv;
      end
      end_t[id] = $time;
      if (!ab) begin
        check(id == 0 ? "frame0" : "frame1", ob, ex);
        check("bit_hold", stab, 1);
        check("done_pulse", dok, 1);
        nfr[id]++;
      end
    end
  endtask

  initial watch(0);
  initial watch(1);

  task automatic push(input int id, input logic [7:0] w);
    int n;
    n = 0;
    while (rdy(id) !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    check("push_rdy", n < 400, 1);
    if (id == 0) begin v0 = 1'b1; d0 = w; end
    else begin v1 = 1'b1; d1 = w[6:0]; end
    @(posedge clk);
    if (id == 0) q0.push_back(w);
    else q1.push_back({1'b0, w[6:0]});
    @(negedge clk);
    if (id == 0) begin v0 = 1'b0; d0 = ~w; end
    else begin v1 = 1'b0; d1 = ~w[6:0]; end
  endtask

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    while ((busy(id) !== 1'b0 || qsz(id) != 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    check("idle", n < 3000, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_serial0", s0, 1);
    check("rst_serial1", s1, 1);
    check("rst_done", dn0, 0);
    check("rst_busy", b0, 0);
    check("rst_level", l0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", r0, 1);

    push(0, 8'hA5);
    check("lat_idle", s0, 1);
    check("lat_busy", b0, 1);
    @(negedge clk);
    check("lat_start", s0, 0);
    wait_idle(0);

    push(1, 8'h07);
    wait_idle(1);
    push(1, 8'h7F);
    push(1, 8'h00);
    wait_idle(1);
    check("abut_gap", gap[1], 0);

    for (int i = 0; i < 5; i++) begin
      check("burst_rdy", r0, 1);
      v0 = 1'b1; d0 = bw[i];
      @(posedge clk);
      q0.push_back(bw[i]);
      @(negedge clk);
    end
    d0 = 8'h66;
    check("full_rdy", r0, 0);
    check("full_lvl", l0, 4);
    n = 0;
    while (r0 !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    check("full_wait", n < 400, 1);
    check("full_lvl_free", l0, 3);
    @(posedge clk);
    q0.push_back(8'h66);
    @(negedge clk);
    v0 = 1'b0;
    wait_idle(0);

    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    n = 0;
    while (dn0 !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    check("pp_wait", n < 400, 1);
    check("pp_lvl_pre", l0, 2);
    v0 = 1'b1; d0 = 8'h3C;
    @(posedge clk);
    q0.push_back(8'h3C);
    @(negedge clk);
    v0 = 1'b0;
    check("pp_lvl_post", l0, 2);
    wait_idle(0);

    push(0, 8'hC3);
    push(0, 8'h99);
    repeat (72) @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    #1;
    check("abort_serial", s0, 1);
    check("abort_level", l0, 0);
    check("abort_busy", b0, 0);
    check("abort_done", dn0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_rdy", r0, 1);
    push(0, 8'h5A);
    wait_idle(0);

    repeat (4) @(negedge clk);
    check("frames0", nfr[0], 12);
    check("frames1", nfr[1], 3);
    check("dones0", dcnt[0], nfr[0]);
    check("dones1", dcnt[1], nfr[1]);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
